// File: rtl/elementwise_pkg.sv
// Shared definitions for the elementwise pipeline.
//   func_e      : configuration function codes (codes 6..15 decode as PASS)
//   op_t        : decoded per-beat operation flags used by every lane
//   decode_func : maps a raw 4-bit function code onto op_t
//   saturate    : clamps a wide signed value into a signed out_w-bit range
package elementwise_pkg;

  typedef enum logic [3:0] {
    FN_PASS      = 4'd0,
    FN_RELU      = 4'd1,
    FN_BIAS      = 4'd2,
    FN_BIAS_RELU = 4'd3,
    FN_REQUANT   = 4'd4,
    FN_MAXPOOL   = 4'd5
  } func_e;

  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 5;
  // Working width for saturation; comfortably above IN_W + MULT_W + 2.
  localparam int SAT_W   = 128;

  typedef struct packed {
    logic use_bias;
    logic relu;
    logic requant;
    logic maxpool;
  } op_t;

  function automatic op_t decode_func(input logic [3:0] code);
    op_t op;
    op = '0;
    case (code)
      FN_RELU:      op.relu = 1'b1;
      FN_BIAS:      op.use_bias = 1'b1;
      FN_BIAS_RELU: begin
        op.use_bias = 1'b1;
        op.relu     = 1'b1;
      end
      FN_REQUANT:   begin
        op.use_bias = 1'b1;
        op.requant  = 1'b1;
      end
      FN_MAXPOOL:   op.maxpool = 1'b1;
      default:      op = '0;
    endcase
    return op;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (out_w - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/elementwise_lane.sv
// One lane of the elementwise pipeline.
//   clk, reset           : clock, asynchronous active-low reset
//   i_op                 : decoded operation flags
//   i_mult/i_shift       : requant multiplier and right shift
//   i_bias               : lane bias
//   i_fire               : input beat accepted this cycle (drives the pool max)
//   i_pool_first         : current beat is the first of a pool window
//   i_en_s1/s2/s3        : stage load enables (advance & valid of previous stage)
//   i_x                  : lane input
//   o_y                  : registered, saturated lane result
module elementwise_lane
  import elementwise_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  op_t                       i_op,
  input  logic signed [MULT_W-1:0]  i_mult,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic signed [IN_W-1:0]    i_bias,
  input  logic                      i_fire,
  input  logic                      i_pool_first,
  input  logic                      i_en_s1,
  input  logic                      i_en_s2,
  input  logic                      i_en_s3,
  input  logic signed [IN_W-1:0]    i_x,
  output logic signed [OUT_W-1:0]   o_y
);

  // Full-width intermediates: bias add grows one bit, the multiply adds
  // MULT_W bits, and the rounding add one more.
  localparam int SUM_W  = IN_W + 1;
  localparam int PROD_W = SUM_W + MULT_W;
  localparam int RND_W  = PROD_W + 1;

  logic signed [IN_W-1:0]   r_max;
  logic signed [IN_W-1:0]   w_pool;
  logic signed [IN_W-1:0]   w_src;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  r_s1;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_s2;
  logic signed [RND_W-1:0]  w_round;
  logic signed [RND_W-1:0]  w_rnd;
  logic signed [RND_W-1:0]  w_shr;
  logic signed [RND_W-1:0]  w_val;
  logic signed [RND_W-1:0]  w_relu;
  logic signed [SAT_W-1:0]  w_sat;
  logic signed [OUT_W-1:0]  r_y;

  // Running max including the current beat; the first beat of a window
  // replaces whatever the previous window left behind.
  assign w_pool = (i_pool_first || (i_x > r_max)) ? i_x : r_max;
  assign w_src  = i_op.maxpool ? w_pool : i_x;
  assign w_sum  = i_op.use_bias ? (SUM_W'(w_src) + SUM_W'(i_bias)) : SUM_W'(w_src);

  assign w_prod = i_op.requant ? (PROD_W'(r_s1) * PROD_W'(i_mult)) : PROD_W'(r_s1);

  // Round-half-up before the arithmetic shift; a zero shift adds nothing.
  assign w_round = (i_shift == '0) ? '0 : (RND_W'(1) <<< (i_shift - SHIFT_W'(1)));
  assign w_rnd   = RND_W'(r_s2) + w_round;
  assign w_shr   = w_rnd >>> i_shift;
  assign w_val   = i_op.requant ? w_shr : RND_W'(r_s2);
  assign w_relu  = (i_op.relu && w_val[RND_W-1]) ? '0 : w_val;
  assign w_sat   = saturate(SAT_W'(w_relu), OUT_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max <= '0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_y   <= '0;
    end else begin
      if (i_fire && i_op.maxpool) r_max <= w_pool;
      if (i_en_s1)                r_s1  <= w_sum;
      if (i_en_s2)                r_s2  <= w_prod;
      if (i_en_s3)                r_y   <= OUT_W'(w_sat);
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/elementwise_pipeline.sv
// Multi-lane elementwise pipeline: PASS / RELU / BIAS / BIAS_RELU /
// REQUANT / MAXPOOL with a 3-stage datapath (bias add, multiply,
// shift/round/saturate) and valid/ready handshakes on both sides.
//   clk, reset            : clock, asynchronous active-low reset
//   cfg_we + cfg_*        : configuration, latched only while idle
//   in_valid/in_ready     : input handshake, in_data NUM x IN_W signed
//   out_valid/out_ready   : output handshake, out_data NUM x OUT_W signed
//   busy                  : data in flight or a pool window partially filled
module elementwise_pipeline
  import elementwise_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 32,
  parameter int CNT_W = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_we,
  input  logic [3:0]                       cfg_func,
  input  logic signed [MULT_W-1:0]         cfg_mult,
  input  logic [SHIFT_W-1:0]               cfg_shift,
  input  logic [CNT_W-1:0]                 cfg_pool_len,
  input  logic signed [NUM-1:0][IN_W-1:0]  cfg_bias,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [NUM-1:0][IN_W-1:0]  in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [NUM-1:0][OUT_W-1:0] out_data,
  output logic                             busy
);

  logic [3:0]               r_func;
  logic signed [MULT_W-1:0] r_mult;
  logic [SHIFT_W-1:0]       r_shift;
  logic [CNT_W-1:0]         r_pool_len;
  logic [NUM-1:0][IN_W-1:0] r_bias;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_v1;
  logic                     r_v2;
  logic                     r_v3;

  op_t              w_op;
  logic [CNT_W-1:0] w_len_eff;
  logic             w_last;
  logic             w_adv;
  logic             w_fire;
  logic             w_load_s1;

  assign w_op      = decode_func(r_func);
  assign w_len_eff = (r_pool_len == '0) ? CNT_W'(1) : r_pool_len;
  assign w_last    = (r_cnt == (w_len_eff - CNT_W'(1)));

  // Every stage moves together; only a stalled, occupied output register
  // blocks the pipe.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = w_adv && reset;
  assign w_fire    = in_valid && in_ready;
  // In MAXPOOL only the closing beat of a window enters the datapath.
  assign w_load_s1 = w_fire && (!w_op.maxpool || w_last);

  assign out_valid = r_v3;
  assign busy      = r_v1 || r_v2 || r_v3 || (r_cnt != '0);

  // Reconfiguration is only accepted while idle, so the stages may read the
  // live configuration registers without per-beat copies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_func     <= FN_PASS;
      r_mult     <= MULT_W'(1);
      r_shift    <= '0;
      r_pool_len <= CNT_W'(1);
      r_bias     <= '0;
      r_cnt      <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
    end else begin
      if (cfg_we && !busy) begin
        r_func     <= cfg_func;
        r_mult     <= cfg_mult;
        r_shift    <= cfg_shift;
        r_pool_len <= cfg_pool_len;
        r_bias     <= cfg_bias;
      end
      if (w_fire && w_op.maxpool) begin
        r_cnt <= w_last ? '0 : (r_cnt + CNT_W'(1));
      end
      if (w_adv) begin
        r_v1 <= w_load_s1;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_lane
      elementwise_lane #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
      ) u_lane (
        .clk          (clk),
        .reset        (reset),
        .i_op         (w_op),
        .i_mult       (r_mult),
        .i_shift      (r_shift),
        .i_bias       (r_bias[gi]),
        .i_fire       (w_fire),
        .i_pool_first (r_cnt == '0),
        .i_en_s1      (w_adv && w_load_s1),
        .i_en_s2      (w_adv && r_v1),
        .i_en_s3      (w_adv && r_v2),
        .i_x          (in_data[gi]),
        .o_y          (out_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_elementwise_pipeline.sv
module tb_elementwise_pipeline;

  typedef logic [3:0][31:0] vec_t;
  typedef logic [3:0][7:0]  vec8_t;
  typedef struct {
    vec_t data;
    int   exp_cyc;
    bit   chk;
  } exp_t;

  localparam int IMIN = 32'sh8000_0000;
  localparam int IMAX = 32'sh7fff_ffff;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_func;
  logic [15:0] cfg_mult;
  logic [4:0]  cfg_shift;
  logic [3:0]  cfg_pool_len;
  vec_t        cfg_bias;
  logic        in_valid;
  logic        in_valid8;
  logic        in_ready;
  logic        in_ready8;
  vec_t        in_data;
  logic        out_valid;
  logic        out_valid8;
  logic        out_ready;
  vec_t        out_data;
  vec8_t       out_data8;
  logic        busy;
  logic        busy8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t  q[$];
  vec8_t q8[$];

  elementwise_pipeline #(.NUM(4), .IN_W(32), .OUT_W(32), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_func(cfg_func),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_pool_len(cfg_pool_len),
    .cfg_bias(cfg_bias), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  elementwise_pipeline #(.NUM(4), .IN_W(32), .OUT_W(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_func(cfg_func),
    .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_pool_len(cfg_pool_len),
    .cfg_bias(cfg_bias), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data), .out_valid(out_valid8), .out_ready(1'b1),
    .out_data(out_data8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  function automatic vec8_t mk8(input int a, input int b, input int c, input int d);
    vec8_t v;
    v[0] = 8'(a); v[1] = 8'(b); v[2] = 8'(c); v[3] = 8'(d);
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_cfg(input logic [3:0] f, input int m, input int s, input int len, input int b);
    @(negedge clk);
    cfg_we       = 1'b1;
    cfg_func     = f;
    cfg_mult     = 16'(m);
    cfg_shift    = 5'(s);
    cfg_pool_len = 4'(len);
    for (int i = 0; i < 4; i++) cfg_bias[i] = b;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input vec_t d, input vec_t e, input bit push, input bit chk_lat,
                      input bit to8, input vec8_t e8);
    int   guard;
    exp_t it;
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    in_valid8 = to8;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else if (push) begin
      it.data    = e;
      it.exp_cyc = cyc + 3;
      it.chk     = chk_lat;
      q.push_back(it);
      if (to8) q8.push_back(e8);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size() + q8.size());
      q.delete();
      q8.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_state_checks(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready),  128'(0));
    chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_busy"},      128'(busy),      128'(0));
    chk({tag, "_out_data"},  128'(out_data),  128'(0));
  endtask

  // Scoreboard monitor: samples just after the falling edge, where the
  // handshake that will complete on the next rising edge is already settled.
  bit   prev_stall = 1'b0;
  vec_t prev_data  = '0;
  always begin
    exp_t  it;
    vec8_t e8;
    @(negedge clk);
    #2;
    if (reset) begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_data !== prev_data) begin
          failures++;
          $display("FAIL stall_hold actual=%h/%0d required=%h/1", out_data, out_valid, prev_data);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready) begin
          failures++;
          $display("FAIL in_ready_stall actual=1 required=0");
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_data);
        end else begin
          it = q.pop_front();
          if (out_data !== it.data) begin
            failures++;
            $display("FAIL out_data actual=%h required=%h", out_data, it.data);
          end
          if (it.chk) begin
            checks++;
            if (cyc != it.exp_cyc) begin
              failures++;
              $display("FAIL latency actual_cycle=%0d required_cycle=%0d", cyc, it.exp_cyc);
            end
          end
        end
      end
      if (out_valid8) begin
        checks++;
        if (q8.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output8 actual=%h required=none", out_data8);
        end else begin
          e8 = q8.pop_front();
          if (out_data8 !== e8) begin
            failures++;
            $display("FAIL out_data8 actual=%h required=%h", out_data8, e8);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_func = '0; cfg_mult = '0; cfg_shift = '0;
    cfg_pool_len = '0; cfg_bias = '0; in_valid = 1'b0; in_valid8 = 1'b0;
    in_data = '0; out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1 reset_state_checks("por");
    @(negedge clk);
    reset = 1'b1;
    #1 chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    // Default configuration is PASS with zero bias
    send(mk(1, -1, IMAX, IMIN), mk(1, -1, IMAX, IMIN), 1, 1, 0, '0);
    drain();

    do_cfg(4'd1, 1, 0, 1, 0);
    send(mk(-5, 0, 7, IMIN), mk(0, 0, 7, 0), 1, 1, 0, '0);
    drain();

    do_cfg(4'd2, 1, 0, 1, 1);
    send(mk(IMAX, 5, -1, IMIN), mk(IMAX, 6, 0, IMIN + 1), 1, 1, 0, '0);
    drain();

    do_cfg(4'd3, 1, 0, 1, 1);
    send(mk(-3, -1, 4, 0), mk(0, 0, 5, 1), 1, 1, 0, '0);
    drain();

    do_cfg(4'd4, 3, 2, 1, 10);
    send(mk(6, IMIN, 0, -7), mk(12, -1610612728, 8, 2), 1, 1, 1, mk8(12, -128, 8, 2));
    drain();

    do_cfg(4'd4, -2, 0, 1, 0);
    send(mk(5, -3, 32'h4000_0000, IMIN), mk(-10, 6, IMIN, IMAX), 1, 1, 0, '0);
    drain();

    do_cfg(4'd4, 1, 1, 1, 0);
    send(mk(-3, 3, -1, 1), mk(-1, 2, 0, 1), 1, 1, 0, '0);
    drain();

    do_cfg(4'd9, 1, 0, 1, 0);
    send(mk(-3, 4, -5, 6), mk(-3, 4, -5, 6), 1, 1, 0, '0);
    drain();

    // Back-to-back PASS beats while out_ready goes 1,0,0,1
    do_cfg(4'd0, 1, 0, 1, 0);
    fork
      begin
        for (int k = 0; k < 6; k++)
          send(mk(k + 1, -(k + 1), k * 1000, 7), mk(k + 1, -(k + 1), k * 1000, 7), 1, 0, 0, '0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        @(negedge clk); out_ready = 1'b0;
        @(negedge clk); out_ready = 1'b1;
      end
    join
    drain();

    do_cfg(4'd5, 1, 0, 3, 0);
    send(mk(4, -1, 0, IMIN), '0, 0, 0, 0, '0);
    send(mk(9, -2, 0, 5),    '0, 0, 0, 0, '0);
    send(mk(-1, -3, 0, 3),   mk(9, -1, 0, 5), 1, 1, 0, '0);
    send(mk(2, -9, 0, 100),  '0, 0, 0, 0, '0);
    send(mk(2, -8, 0, -100), '0, 0, 0, 0, '0);
    send(mk(8, -7, 0, 0),    mk(8, -7, 0, 100), 1, 1, 0, '0);
    drain();
    chk("busy_after_pool", 128'(busy), 128'(0));

    do_cfg(4'd5, 1, 0, 0, 0);
    send(mk(3, -4, 5, -6), mk(3, -4, 5, -6), 1, 1, 0, '0);
    send(mk(1, 2, 3, 4),   mk(1, 2, 3, 4),   1, 1, 0, '0);
    drain();
    chk("busy_after_len0", 128'(busy), 128'(0));

    // Configuration write while busy must be dropped
    do_cfg(4'd0, 1, 0, 1, 0);
    send(mk(-1, -2, -3, -4), mk(-1, -2, -3, -4), 1, 1, 0, '0);
    chk("busy_in_flight", 128'(busy), 128'(1));
    do_cfg(4'd1, 1, 0, 1, 0);
    drain();
    send(mk(-5, -6, -7, -8), mk(-5, -6, -7, -8), 1, 1, 0, '0);
    drain();

    // Reset after two of three pool beats
    do_cfg(4'd5, 1, 0, 3, 0);
    send(mk(100, 100, 100, 100), '0, 0, 0, 0, '0);
    send(mk(50, 50, 50, 50),     '0, 0, 0, 0, '0);
    chk("busy_partial_pool", 128'(busy), 128'(1));
    @(negedge clk);
    reset = 1'b0;
    #1 reset_state_checks("mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("out_valid_after_mid_reset", 128'(out_valid), 128'(0));
    send(mk(-9, 9, -9, 9), mk(-9, 9, -9, 9), 1, 1, 0, '0);
    drain();
    do_cfg(4'd5, 1, 0, 3, 0);
    send(mk(1, -5, 0, 7), '0, 0, 0, 0, '0);
    send(mk(2, -6, 0, 6), '0, 0, 0, 0, '0);
    send(mk(3, -7, 0, 5), mk(3, -5, 0, 7), 1, 1, 0, '0);
    drain();
    chk("busy_final", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
